// File: rtl/if_id_stage_pkg.sv
// Shared IF/ID widths and bubble value for the MIPS core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_id_stage_pkg;

   // Default PC and instruction widths used across the core.
   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   // Value presented on the decode side when no instruction is valid.
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage : if_id_stage_pkg

// File: rtl/if_id_fifo.sv
// Circular buffer core: DEPTH entries of WIDTH bits, pointer/count bookkeeping.
// Latency: a write at edge N is readable at rdata_o in the cycle after edge N.
// Backpressure: caller must not push when count_o == DEPTH nor pop when count_o == 0.
// Ports: clk/rst (sync, active-high), clr_i (sync clear of pointers/count),
//        push_i/wdata_i (write side), pop_i/rdata_o (head), count_o (occupancy).
module if_id_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   import if_id_stage_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W:0]   count_q, count_d;

   // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0 for free.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (clr_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + 1'b1;
         if (pop_i)  rptr_d = rptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Storage is never cleared; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule : if_id_fifo

// File: rtl/if_id_stage.sv
// IF->ID elastic pipeline stage with flush and saturating stall counter.
// Latency: 1 cycle from accepted fetch pair to id_valid; 1 pair/cycle sustained.
// Backpressure: if_ready = (count < DEPTH), no pass-through when full.
// Ports: clk/rst (sync, active-high); if_valid/if_ready/if_pc/if_inst from fetch;
//        id_valid/id_ready/id_pc/id_inst to decode (zeroed when empty);
//        flush (drop buffered + incoming); stall_cnt (id_valid & !id_ready cycles).
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int ADDR_W = InstAddrBus,
   parameter int INST_W = InstBus,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W:0]             count;
   logic [ADDR_W+INST_W-1:0]   head;
   logic                       push, pop;
   logic [CNT_W-1:0]           stall_q, stall_d;

   assign if_ready = (count < FULL_CNT);
   assign id_valid = (count != '0);
   // A push in a flush cycle is dropped; a pop in a flush cycle still counts
   // as consumed by decode, the clear simply wins inside the core.
   assign push     = if_valid & if_ready & ~flush;
   assign pop      = id_valid & id_ready;

   if_id_fifo #(
      .WIDTH (ADDR_W + INST_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .push_i  (push),
      .wdata_i ({if_pc, if_inst}),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );

   // Stale storage must never leak to decode, so gate to the bubble value.
   assign id_pc   = id_valid ? head[ADDR_W+INST_W-1:INST_W] : ADDR_W'(ZeroWord);
   assign id_inst = id_valid ? head[INST_W-1:0]             : INST_W'(ZeroWord);

   always_comb begin
      stall_d = stall_q;
      if (id_valid && !id_ready && !(&stall_q)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;

endmodule : if_id_stage

// File: doc/if_id_stage.md
# if_id_stage

Parametrised, clocked IF→ID pipeline stage for the MIPS core. It replaces a flow-through PC/instruction latch with a valid/ready elastic buffer of DEPTH entries. It supports synchronous flush for branch/exception redirect and a saturating stall-cycle counter. It sits between the instruction-fetch unit (upstream) and the decoder (downstream).

## Interface
Parameters:
- ADDR_W, 32, PC width in bits
- INST_W, 32, instruction width in bits
- DEPTH, 2, buffer entries; legal values 2, 4, 8
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch presents a PC/instruction pair
- if_ready  out  1  stage can accept a pair this cycle
- if_pc  in  ADDR_W  fetched PC
- if_inst  in  INST_W  fetched instruction
- id_valid  out  1  head entry valid toward decode
- id_ready  in  1  decode consumes the head this cycle
- id_pc  out  ADDR_W  head PC; zero when id_valid=0
- id_inst  out  INST_W  head instruction; zero (NOP) when id_valid=0
- flush  in  1  discard all buffered and incoming entries
- stall_cnt  out  CNT_W  cycles with id_valid=1 and id_ready=0, saturating

## Operation
- Storage is a circular buffer with DEPTH entries, a read pointer, a write pointer (log2(DEPTH) bits each, wrapping naturally), and a count (log2(DEPTH)+1 bits).
- push = if_valid & if_ready & !flush.
- pop = id_valid & id_ready.
- if_ready = (count < DEPTH). It is combinational from count only and does not depend on flush or id_ready, so there is no pass-through when full.
- id_valid = (count != 0). id_pc and id_inst come from the head entry, gated to zero when the buffer is empty.
- Push only: write at wptr, wptr+1, count+1.
- Pop only: rptr+1, count−1.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any count < DEPTH.
- Flush:
  - Next cycle count=0 and rptr=wptr=0.
  - The same-cycle push is dropped.
  - A same-cycle pop is treated as completed by decode.
  - Storage contents are not cleared.
- stall_cnt increments when id_valid & !id_ready and holds at all-ones. It is not cleared by flush.
- Priority: rst > flush > push/pop.
- Data is stored unmodified. The stage does no arithmetic on the PC.

## Timing
- Reset values: count=0, pointers=0, stall_cnt=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1.
- rst asserted mid-operation takes effect on the next edge and drops all entries regardless of flush or handshakes.
- Latency: a pair pushed at edge N into an empty buffer appears on id_* with id_valid=1 in the cycle after edge N (1 cycle).
- Throughput: 1 pair per cycle sustained when id_ready is held high.
- Full (count=DEPTH): if_ready=0. When a pop occurs, if_ready rises the cycle after.
- Empty: id_valid=0 and outputs are zero. id_ready is ignored.
- Flush in cycle N: id_valid=0 from cycle N+1. A new push is accepted in cycle N+1 and becomes visible in cycle N+2.
- Pointer wrap from DEPTH−1 to 0 must be seamless, with no lost or duplicated entries.

## Structure
- ADDR_W/INST_W defaults map to the shared InstAddrBus/InstBus widths. ZeroWord (the reset/bubble value) also belongs in the shared defines, so no new package is needed.
- Natural sub-module: if_id_fifo, the pointer/count/storage core, parametrised by width and depth. The top level adds flush, output gating and stall_cnt.

## Test plan
- Reset then stream: rst 2 cycles, then push PCs 0x00400000, 0x00400004, 0x00400008 with id_ready=1 → id_pc presents each one cycle after its push, id_valid continuous, stall_cnt=0.
- Fill/backpressure (DEPTH=2): id_ready=0, push 3 pairs → first two accepted, if_ready=0 after the second, third held by fetch. Raise id_ready → order 1, 2, 3 preserved. stall_cnt equals the number of cycles held low.
- Flush with simultaneous push and pop: 2 entries buffered, assert flush with if_valid=1 and id_ready=1 → next cycle id_valid=0, id_inst=0, count=0, pushed pair absent.
- Wrap-around (DEPTH=4): 10 pushes with random id_ready → outputs match a scoreboard exactly across pointer wrap.
- Saturation (CNT_W=4): hold id_valid=1, id_ready=0 for 20 cycles → stall_cnt stops at 0xF.
- Reset mid-stream: rst during a full buffer with flush=1 → next cycle all outputs at reset values, if_ready=1.
